// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter feeding multi-byte words into one UART transmitter
module uart_tx_arbiter #(
    parameter int D_BIT = 8,
    parameter int N_REQ = 2,
    parameter int BYTES = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ*BYTES*D_BIT-1:0] word_in,
    output logic [N_REQ-1:0]             ack,
    output logic                         busy,
    output logic [D_BIT-1:0]             tx_data,
    output logic                         tx_start,
    input  logic                         tx_done
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int WW = BYTES * D_BIT;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_CLEAR,
        S_ACK
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WW-1:0]   shift_reg;
    logic [CW-1:0]   byte_cnt;
    logic [IW-1:0]   last;
    logic [IW-1:0]   grant;
    logic            found;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   cand;
    logic [WW-1:0]   sel_word;
    logic            last_byte;

    assign last_byte = (byte_cnt == CW'(BYTES - 1));

    // Search starts just past the previous winner so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(last) + k) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick == IW'(i)) begin
                sel_word = word_in[i*WW +: WW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (found) state_next = S_LOAD;
            S_LOAD:  state_next = S_SEND;
            S_SEND:  if (tx_done) state_next = S_CLEAR;
            S_CLEAR: if (!tx_done) state_next = last_byte ? S_ACK : S_LOAD;
            S_ACK:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            byte_cnt  <= '0;
            last      <= IW'(N_REQ - 1);
            grant     <= '0;
            tx_data   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        shift_reg <= sel_word;
                        last      <= pick;
                        grant     <= pick;
                    end
                end
                S_LOAD: tx_data <= shift_reg[D_BIT-1:0];
                S_CLEAR: begin
                    if (!tx_done && !last_byte) begin
                        shift_reg <= shift_reg >> D_BIT;
                        byte_cnt  <= byte_cnt + 1'b1;
                    end
                end
                S_ACK: byte_cnt <= '0;
                default: ;
            endcase
        end
    end

    // tx_data stays registered through SEND and CLEAR; the transmitter samples it live.
    always_comb begin
        ack      = '0;
        tx_start = (state == S_SEND);
        busy     = (state != S_IDLE);
        if (state == S_ACK) begin
            ack[grant] = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed bench for uart_tx_arbiter with a behavioural transmitter
module tb_uart_tx_arbiter;

    localparam int FRAME = 10;
    localparam int LIMIT = 2000;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [63:0] word_in;
    logic [1:0]  ack;
    logic        busy;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done;

    int errors;
    int checks;
    int hs_err;
    int ack_cnt;
    int xm_st;
    int xm_cnt;
    logic [7:0] xm_byte;
    logic [7:0] line_q[$];

    uart_tx_arbiter #(.D_BIT(8), .N_REQ(2), .BYTES(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .word_in  (word_in),
        .ack      (ack),
        .busy     (busy),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_done  (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transmitter stand-in: frame of FRAME cycles, then tx_done held for 3 cycles.
    initial begin
        xm_st   = 0;
        xm_cnt  = 0;
        xm_byte = '0;
        tx_done = 1'b0;
        hs_err  = 0;
    end

    always @(negedge clk) begin
        if (reset) begin
            xm_st   = 0;
            tx_done = 1'b0;
        end else begin
            case (xm_st)
                0: if (tx_start) begin
                    xm_byte = tx_data;
                    line_q.push_back(tx_data);
                    if (!busy) hs_err++;
                    xm_cnt = 0;
                    xm_st  = 1;
                end
                1: begin
                    if (tx_data !== xm_byte) hs_err++;
                    xm_cnt++;
                    if (xm_cnt == FRAME) begin
                        tx_done = 1'b1;
                        xm_cnt  = 0;
                        xm_st   = 2;
                    end
                end
                2: begin
                    if (tx_start) hs_err++;
                    xm_cnt++;
                    if (xm_cnt == 3) begin
                        tx_done = 1'b0;
                        xm_st   = 0;
                    end
                end
                default: xm_st = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (ack != 2'b00) ack_cnt++;
    end

    task automatic wait_ack(output logic [1:0] a);
        a = 2'b00;
        for (int n = 0; n < LIMIT; n++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                a = ack;
                return;
            end
        end
    endtask

    task automatic wait_line(input int sz);
        for (int n = 0; n < LIMIT && line_q.size() < sz; n++) @(negedge clk);
    endtask

    logic [1:0]  a;
    logic [31:0] w;
    int          n;

    initial begin
        errors  = 0;
        checks  = 0;
        ack_cnt = 0;
        reset   = 1'b1;
        req     = 2'b00;
        word_in = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_ack", 64'(ack), 0);
        check_eq("rst_busy", 64'(busy), 0);
        check_eq("rst_tx_start", 64'(tx_start), 0);
        check_eq("rst_tx_data", 64'(tx_data), 0);

        // single word
        line_q.delete();
        reset = 1'b0;
        word_in[31:0] = 32'h4433_2211;
        req = 2'b01;
        n = 0;
        while (!tx_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("t1_grant_to_start", 64'(n), 2);
        wait_ack(a);
        check_eq("t1_ack", 64'(a), 64'h1);
        check_eq("t1_busy_at_ack", 64'(busy), 1);
        req = 2'b00;
        @(negedge clk);
        check_eq("t1_busy_after", 64'(busy), 0);
        check_eq("t1_ack_pulse", 64'(ack), 0);
        check_eq("t1_nbytes", 64'(line_q.size()), 4);
        w = 32'h4433_2211;
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("t1_byte%0d", i), 64'(line_q[i]), 64'(w[i*8 +: 8]));

        // late request and word change after grant
        line_q.delete();
        word_in[63:32] = 32'h9988_7766;
        req = 2'b01;
        wait_line(1);
        req = 2'b11;
        word_in[31:0] = 32'hDEAD_BEEF;
        wait_ack(a);
        check_eq("t3_ack0", 64'(a), 64'h1);
        req = 2'b10;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < 50);
        check_eq("t3_ack_to_grant", 64'(n), 2);
        wait_ack(a);
        check_eq("t3_ack1", 64'(a), 64'h2);
        req = 2'b00;
        check_eq("t3_nbytes", 64'(line_q.size()), 8);
        w = 32'h4433_2211;
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("t3_w0_byte%0d", i), 64'(line_q[i]), 64'(w[i*8 +: 8]));
        w = 32'h9988_7766;
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("t3_w1_byte%0d", i), 64'(line_q[4+i]), 64'(w[i*8 +: 8]));
        @(negedge clk);

        // round robin with both held; last winner was requester 1
        line_q.delete();
        word_in = {32'h5555_5555, 32'hAAAA_AAAA};
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_ack(a);
            check_eq($sformatf("t2_ack%0d", i), 64'(a), (i % 2 == 1) ? 64'h2 : 64'h1);
        end
        req = 2'b00;
        repeat (3) @(negedge clk);
        check_eq("t2_nbytes", 64'(line_q.size()), 16);
        for (int i = 0; i < 16; i++)
            check_eq($sformatf("t2_byte%0d", i), 64'(line_q[i]),
                     ((i / 4) % 2 == 1) ? 64'h55 : 64'hAA);

        // reset mid-word, then pointer must start from requester 0 again
        line_q.delete();
        word_in = {32'h9988_7766, 32'h4433_2211};
        req = 2'b01;
        wait_line(2);
        repeat (3) @(negedge clk);
        ack_cnt = 0;
        reset = 1'b1;
        @(negedge clk);
        check_eq("t4_rst_ack", 64'(ack), 0);
        check_eq("t4_rst_busy", 64'(busy), 0);
        check_eq("t4_rst_tx_start", 64'(tx_start), 0);
        @(negedge clk);
        check_eq("t4_no_ack", 64'(ack_cnt), 0);
        line_q.delete();
        reset = 1'b0;
        req = 2'b11;
        wait_ack(a);
        check_eq("t4_first_after_rst", 64'(a), 64'h1);
        check_eq("t4_restart_byte0", 64'(line_q[0]), 64'h11);
        req = 2'b00;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req = 2'b10;
        wait_ack(a);
        check_eq("t4_only_req1", 64'(a), 64'h2);
        req = 2'b00;
        repeat (3) @(negedge clk);

        check_eq("handshake", 64'(hs_err), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between N_REQ requesters (CPU debug unit, register dump, memory dump), round-robin.
- Each request carries one BYTES-byte word; the block latches it, serializes it byte by byte into the transmitter, and pulses an acknowledge to the winning requester once the word is fully sent.
- Sits between the requesters and the transmitter's d_in / tx_start / tx_done pins.

Parameters:
- D_BIT, 8, bits per UART byte; must match the transmitter's D_BIT.
- N_REQ, 2, number of requesters, 1..4.
- BYTES, 4, bytes per word, 1..8.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N_REQ  level request, one bit per requester; held until its ack.
- word_in  input  N_REQ*BYTES*D_BIT  word for requester i at bits [(i+1)*BYTES*D_BIT-1 : i*BYTES*D_BIT].
- ack  output  N_REQ  one-cycle pulse to requester i when its word is completely sent.
- busy  output  1  high from grant until ack, inclusive.
- tx_data  output  D_BIT  byte to the transmitter's d_in.
- tx_start  output  1  to the transmitter's tx_start.
- tx_done  input  1  from the transmitter's tx_done.

Behaviour:
- Reset values: ack=0, busy=0, tx_data=0, tx_start=0, byte counter=0, last-grant pointer=N_REQ-1 (requester 0 has highest priority first), state=IDLE.
- Reset mid-word aborts the word with no ack. System reset must also reset or idle the transmitter.
- IDLE:
  - If any req bit is set, grant the first set bit searching from (last+1) mod N_REQ upward with wrap-around.
  - Latch that requester's word into an internal shift register, set last=granted index, set busy=1, go to LOAD.
  - Arbitration happens only in IDLE. Requests arriving mid-word wait.
- LOAD (1 cycle): tx_data <= lowest byte of the shift register (LSB byte first), then go to SEND.
- SEND: tx_start=1 and tx_data held stable. Wait for tx_done==1, then go to CLEAR.
- CLEAR:
  - tx_start=0; wait for tx_done==0.
  - Then, if the byte counter equals BYTES-1, go to ACK.
  - Otherwise shift the register right by D_BIT, increment the counter, and go to LOAD.
- ACK (1 cycle): ack[granted]=1, busy stays 1, counter <= 0. Then go to IDLE with busy=0 on the next cycle.
- Transmitter constraints:
  - tx_data must be held for the whole frame, because the transmitter reads d_in live in every data bit.
  - tx_start must be low before the transmitter's next s_tick after it raises tx_done. This requires an s_tick period of at least 2 clk cycles.
  - tx_done stays high until the transmitter's next idle tick; CLEAR absorbs this.
- Word latching: word_in is sampled only at grant. Later changes to word_in do not affect the word in flight.
- A requester dropping req after grant does not abort the word; ack is still pulsed.
- req and ack on the same cycle: the requester may keep req high for a new word. It is eligible at the next IDLE, but only after other pending requesters (round-robin).
- Latency: grant to first tx_start = 2 cycles. Last tx_done fall to ack = 1 cycle. Ack to the next grant = 1 cycle.
- With a single requester (N_REQ=1), it is always granted.

Test Plan:
- Single word: reset, req=01, word0=0x44332211, BYTES=4 → tx bytes 0x11,0x22,0x33,0x44 in order on the serial line; one ack[0] pulse; busy high throughout.
- Round-robin: req=11 held, word0=0xAAAAAAAA, word1=0x55555555 → words alternate 0,1,0,1. ack pulses alternate ack[0],ack[1]; neither requester is starved.
- Late request: req=01; while the first byte is in flight raise req[1] → word 0 completes fully (4 bytes), then word 1 is granted 1 cycle after ack[0].
- Input change after grant: change word_in[0] to 0xDEADBEEF during byte 1 → line still carries the originally latched 0x44332211.
- Handshake check: tx_start falls within 1 clk of tx_done rising; tx_data is stable from LOAD until tx_done rises, for every byte.
- Reset mid-word: assert reset during byte 2 (transmitter also reset) → ack=0, busy=0, tx_start=0. A subsequent req=10 is granted requester 0 first if req=11, otherwise requester 1.
